mul32_sched: RTL
================

MUL32_SCHED -- requirements
Module: mul32_sched

Interface
REQ-001 The module SHALL have parameter LAT, default 2, meaning the number of clock cycles allowed for the combinational multiplier to settle; legal range 1..15.
REQ-002 The module SHALL have clk  input  1  the single clock, with all state updating on its rising edge.
REQ-003 The module SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The module SHALL have, for each requester k in {0,1}, reqk_valid  input  1  request present.
REQ-005 The module SHALL have, for each requester k, reqk_ready  output  1  request accepted this cycle.
REQ-006 The module SHALL have, for each requester k, reqk_a and reqk_b  input  32 each  the operands.
REQ-007 The module SHALL have, for each requester k, reqk_mode  input  1  operand interpretation, 1 = signed and 0 = unsigned.
REQ-008 The module SHALL have m_a and m_b  output  32 each, and m_mode  output  1, which drive the multiplier.
REQ-009 The module SHALL have m_lo and m_hi  input  32 each  the multiplier product halves.
REQ-010 The module SHALL have resp_valid  output  1  result available.
REQ-011 The module SHALL have resp_ready  input  1  consumer accepts the result.
REQ-012 The module SHALL have resp_id  output  1  index of the requester that owns the result.
REQ-013 The module SHALL have resp_prod  output  64  the product {hi,lo}.
REQ-014 The module SHALL have ops_cnt  output  16  the count of completed responses.

Function
REQ-015 The state machine SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-016 Arbitration in IDLE SHALL work as follows:
- grant goes to the single valid requester;
- if both requesters are valid, grant goes to the requester not granted last (round-robin);
- last_grant resets to 1, so req0 wins the first tie.
REQ-017 reqk_ready SHALL be 1 only in IDLE and only for the granted requester; it is combinational from the valid inputs and state, and 0 in BUSY and DONE.
REQ-018 Acceptance SHALL be reqk_valid && reqk_ready at a rising edge, and on acceptance:
- the operands, mode and id are latched;
- last_grant is set to k;
- the counter is cleared to 0;
- the state moves to BUSY.
REQ-019 m_a, m_b and m_mode SHALL be driven from the latched registers only, and SHALL stay stable from acceptance until the state next leaves DONE.
REQ-020 In BUSY, the counter SHALL increment every cycle; at the edge where the counter equals LAT-1:
- resp_prod <= {m_hi, m_lo};
- the state moves to DONE.
REQ-021 resp_valid SHALL be 1 exactly when the state is DONE, which makes it first high LAT cycles after the acceptance edge.
REQ-022 In DONE, if resp_ready=1 at the edge, the response is consumed: ops_cnt increments (wrapping 0xFFFF->0x0000) and the state returns to IDLE.
REQ-023 A new request SHALL NOT be accepted in the consume cycle, giving a minimum issue interval of LAT+2 cycles.
REQ-024 resp_prod and resp_id SHALL hold stable while resp_valid=1 and resp_ready=0, for any duration.
REQ-025 resp_ready=1 outside DONE SHALL have no effect.
REQ-026 A requester that deasserts valid before being granted SHALL have no effect, and no request SHALL be lost or duplicated.
REQ-027 Simultaneous acceptance and consumption SHALL be impossible by construction, since the two are in different states.

Reset
REQ-028 While rst_n=0, the module SHALL immediately hold the following values, independent of clk:
- state=IDLE;
- last_grant=1;
- counter=0;
- latched operands, m_a, m_b, m_mode, resp_prod, resp_id = 0;
- ops_cnt=0;
- resp_valid=0;
- reqk_ready=0.
REQ-029 Reset asserted mid-operation (in BUSY or DONE) SHALL discard the operation with no response and no increment of ops_cnt.
REQ-030 After rst_n deasserts, the first rising edge SHALL already be able to accept a request.

Verification
REQ-031 Bench scenario: req0 unsigned a=292, b=6785, resp_ready=1, LAT=2 -> resp_valid rises 2 cycles after acceptance, resp_prod=1981220, resp_id=0, ops_cnt=1.
REQ-032 Bench scenario: req1 signed a=-3, b=7 -> resp_prod=0xFFFFFFFFFFFFFFEB and resp_id=1; the same operands unsigned -> 0x00000006FFFFFFEB.
REQ-033 Bench scenario: unsigned 0xFFFFFFFF*0xFFFFFFFF -> resp_prod=0xFFFFFFFE00000001; signed 0x80000000*0x80000000 -> 0x4000000000000000.
REQ-034 Bench scenario: both valid continuously after reset -> grants alternate 0,1,0,1; resp_id follows the same sequence; no grant occurs in BUSY or DONE.
REQ-035 Bench scenario: resp_ready held 0 for 10 cycles in DONE -> resp_valid stays 1 with stable data; both ready signals stay 0; ops_cnt is unchanged until consumption.
REQ-036 Bench scenario: rst_n pulsed low in BUSY -> resp_valid stays 0, ops_cnt=0, and the next request completes normally with the correct product.

Source files
------------

// File: rtl/mul32_sched.sv
// Two-requester scheduler for a shared combinational 32x32 multiplier.
// Round-robin grant, operands held for LAT settle cycles, result held until consumed.
module mul32_sched #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_mode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_mode,
  output logic [31:0] m_a,
  output logic [31:0] m_b,
  output logic        m_mode,
  input  logic [31:0] m_lo,
  input  logic [31:0] m_hi,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [63:0] resp_prod,
  output logic [15:0] ops_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(LAT - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        mode_q, mode_d;
  logic        id_q, id_d;
  logic [63:0] prod_q, prod_d;
  logic [15:0] ops_q, ops_d;
  logic        gnt;
  logic        any_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      id_q    <= 1'b0;
      prod_q  <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      id_q    <= id_d;
      prod_q  <= prod_d;
      ops_q   <= ops_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    id_d       = id_q;
    prod_d     = prod_q;
    ops_d      = ops_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    any_vld    = req0_valid | req1_valid;
    // On a tie the requester not served last wins; otherwise the lone requester.
    gnt        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    case (state_q)
      IDLE: begin
        req0_ready = rst_n & any_vld & ~gnt;
        req1_ready = rst_n & any_vld & gnt;
        if (any_vld) begin
          a_d     = gnt ? req1_a : req0_a;
          b_d     = gnt ? req1_b : req0_b;
          mode_d  = gnt ? req1_mode : req0_mode;
          id_d    = gnt;
          last_d  = gnt;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          prod_d  = {m_hi, m_lo};
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          ops_d   = ops_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_a        = a_q;
  assign m_b        = b_q;
  assign m_mode     = mode_q;
  assign resp_valid = (state_q == DONE);
  assign resp_id    = id_q;
  assign resp_prod  = prod_q;
  assign ops_cnt    = ops_q;

endmodule
